deadtime_gate: RTL and testbench
================================

DEADTIME_GATE -- requirements
Module: deadtime_gate

Interface
REQ-001 The module SHALL have parameter DT_WIDTH, default 8, giving the dead-time counter and register width in clk cycles.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port MMS_addr, input, 2 bits: Avalon slave word address.
REQ-005 The module SHALL have port MMS_write, input, 1 bit: Avalon write strobe.
REQ-006 The module SHALL have port MMS_writedata, input, 32 bits: Avalon write data.
REQ-007 The module SHALL have port Udrive, input, [0:2]: high-side demand per phase from the PWM modulator.
REQ-008 The module SHALL have port Ldrive, input, [0:2]: low-side demand per phase from the PWM modulator.
REQ-009 The module SHALL have port trip_n, input, 1 bit: external overcurrent trip, active low, already synchronous to clk.
REQ-010 The module SHALL have port Ugate, output, [0:2]: registered high-side gate drive.
REQ-011 The module SHALL have port Lgate, output, [0:2]: registered low-side gate drive.
REQ-012 The module SHALL have port faultirq, output, 1 bit: one-cycle pulse when the fault latch sets.

Function
REQ-013 Writes SHALL decode as follows: addr 0 loads the dead-time register from writedata[DT_WIDTH-1:0]; addr 1 loads the enable bit from writedata[0]; addr 2 with writedata[0]=1 requests a fault clear; addr 3 is ignored.
REQ-014 Per phase, the request SHALL be U when Udrive=1 and Ldrive=0, L when Ldrive=1 and Udrive=0, and NONE otherwise.
REQ-015 Each phase SHALL run an independent FSM with states IDLE, U_ON and L_ON, plus a DT_WIDTH-bit down-counter.
REQ-016 IDLE: Ugate=0 and Lgate=0; the counter decrements and saturates at 0; the FSM goes to U_ON (or L_ON) when the counter is 0 and the request is U (or L).
REQ-017 U_ON: Ugate=1; when the request is not U, the FSM goes to IDLE and loads the counter with the dead-time register. L_ON SHALL behave symmetrically.
REQ-018 Gate outputs SHALL be registered, with one clk of latency from a request change to the gate change.
REQ-019 The off-to-on gap between complementary gates SHALL be dead-time+1 cycles; dead-time 0 still gives 1 cycle with both gates low.
REQ-020 A request change during IDLE SHALL neither reload nor restart the counter.
REQ-021 Ugate and Lgate of the same phase SHALL never be 1 in the same cycle under any input sequence.
REQ-022 A dead-time register write SHALL take effect at the next counter load only; counts in progress are unaffected.
REQ-023 The fault latch SHALL set on any cycle with trip_n=0 while enable=1.
REQ-024 While fault=1 or enable=0, all FSMs SHALL be forced to IDLE with the counter loaded to the dead-time register, and all gates SHALL be 0 on the next edge.
REQ-025 faultirq SHALL be 1 for exactly the one cycle after the fault latch goes 0 to 1.
REQ-026 A fault-clear write SHALL clear the latch only if trip_n=1 in that cycle; otherwise it is ignored.
REQ-027 If trip_n=0 and a fault-clear write occur in the same cycle, the fault SHALL remain set.
REQ-028 The enable bit SHALL be independent of the fault latch; the fault latch does not clear enable.

Reset
REQ-029 When reset=1: Ugate=0, Lgate=0, faultirq=0, fault=0, enable=0, dead-time register = all ones, all FSMs in IDLE, and all counters = all ones.
REQ-030 Reset asserted mid-operation SHALL force every output to 0 at the next edge, overriding any in-flight dead-time count or write.

Configuration
REQ-031 With SHOOT_THROUGH_DETECT_EN defined, Udrive=1 and Ldrive=1 on the same phase while enable=1 SHALL set the fault latch exactly as trip_n=0 does, including the faultirq pulse.
REQ-032 With SHOOT_THROUGH_DETECT_EN undefined, that input combination SHALL be treated as request NONE only, with no fault.

Verification
REQ-033 Scenario: dead-time=5, enable=1, phase 0 holds L_ON, then Udrive[0] rises with Ldrive[0] falling -> Lgate[0]=0 after 1 cycle, Ugate[0]=1 exactly 6 cycles after Lgate[0] falls.
REQ-034 Scenario: dead-time=0, phase 1 toggles U/L every cycle -> both gates never high together; each gate turns on 2 cycles after its request.
REQ-035 Scenario: phase 2 in U_ON, trip_n=0 for 1 cycle -> all gates 0 next edge; faultirq high 1 cycle; gates stay 0 after trip_n returns to 1; a clear write at addr 2, then dead-time+1 cycles later, gates follow requests.
REQ-036 Scenario: clear write while trip_n=0 -> fault stays set, no second faultirq.
REQ-037 Scenario: dead-time=10, mid-count write dead-time=2 -> current gap stays 11 cycles, next gap is 3 cycles.
REQ-038 Scenario: with SHOOT_THROUGH_DETECT_EN defined, Udrive[0]=Ldrive[0]=1 for 1 cycle -> fault set and faultirq pulses; undefined -> gates 0, no fault.

Source files
------------

// File: rtl/deadtime_gate.sv
// -----------------------------------------------------------------------------
// deadtime_gate
//   Three-phase gate-drive dead-time inserter with an overcurrent fault latch.
//   Each phase turns U/L demands from the PWM modulator into registered
//   complementary gate drives. At least dead-time+1 clk cycles with both gates
//   low are guaranteed between one gate turning off and its complement
//   turning on.
//
// Parameters
//   DT_WIDTH       dead-time register / counter width in clk cycles (default 8)
//
// Ports
//   clk            single clock, everything on the rising edge
//   reset          synchronous active-high reset
//   MMS_addr       Avalon slave word address
//                    0: dead-time
//                    1: enable (bit 0)
//                    2: fault clear (bit 0 = 1)
//                    3: unused
//   MMS_write      Avalon write strobe
//   MMS_writedata  Avalon write data
//   Udrive[0:2]    high-side demand per phase
//   Ldrive[0:2]    low-side demand per phase
//   trip_n         overcurrent trip, active low, already synchronous to clk
//   Ugate[0:2]     registered high-side gate drive
//   Lgate[0:2]     registered low-side gate drive
//   faultirq       one-cycle pulse when the fault latch sets
//
// Build option
//   SHOOT_THROUGH_DETECT_EN  when defined, Udrive=Ldrive=1 on any phase while
//                            enabled trips the fault latch like trip_n=0 does.
//                            When undefined, that combination is only a NONE
//                            request.
// -----------------------------------------------------------------------------
module deadtime_gate #(
  parameter int DT_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MMS_addr,
  input  logic        MMS_write,
  input  logic [31:0] MMS_writedata,
  input  logic [0:2]  Udrive,
  input  logic [0:2]  Ldrive,
  input  logic        trip_n,
  output logic [0:2]  Ugate,
  output logic [0:2]  Lgate,
  output logic        faultirq
);

  localparam int NPH = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_U_ON = 2'd1;
  localparam logic [1:0] ST_L_ON = 2'd2;

  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_U    = 2'd1;
  localparam logic [1:0] REQ_L    = 2'd2;

  localparam logic [DT_WIDTH-1:0] DT_ONES = {DT_WIDTH{1'b1}};
  localparam logic [DT_WIDTH-1:0] DT_ZERO = {DT_WIDTH{1'b0}};
  localparam logic [DT_WIDTH-1:0] DT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};

  // Register file and fault latch
  logic [DT_WIDTH-1:0] dt_q, dt_d;
  logic                enable_q, enable_d;
  logic                fault_q, fault_d;
  logic                faultirq_q, faultirq_d;

  // Per-phase state
  logic [1:0]          state_q [0:NPH-1];
  logic [1:0]          state_d [0:NPH-1];
  logic [DT_WIDTH-1:0] cnt_q   [0:NPH-1];
  logic [DT_WIDTH-1:0] cnt_d   [0:NPH-1];
  logic [0:2]          ugate_q, ugate_d;
  logic [0:2]          lgate_q, lgate_d;

  logic [1:0]          req_s [0:NPH-1];
  logic                clr_req_s;
  logic                shoot_s;
  logic                fault_set_s;
  logic                force_idle_s;

  // Only the low dead-time bits and bit 0 are architecturally meaningful.
  logic                unused_wdata_s;
  assign unused_wdata_s = ^MMS_writedata;

`ifdef SHOOT_THROUGH_DETECT_EN
  assign shoot_s = |(Udrive & Ldrive);
`else
  assign shoot_s = 1'b0;
`endif

  // Decode each phase's demand pair into a single request; both-high means NONE.
  always_comb begin
    for (int i = 0; i < NPH; i++) begin
      if (Udrive[i] && !Ldrive[i]) begin
        req_s[i] = REQ_U;
      end else if (Ldrive[i] && !Udrive[i]) begin
        req_s[i] = REQ_L;
      end else begin
        req_s[i] = REQ_NONE;
      end
    end
  end

  // Avalon write decode for dead-time, enable and fault-clear request.
  always_comb begin
    dt_d      = dt_q;
    enable_d  = enable_q;
    clr_req_s = 1'b0;
    if (MMS_write) begin
      case (MMS_addr)
        2'd0:    dt_d      = MMS_writedata[DT_WIDTH-1:0];
        2'd1:    enable_d  = MMS_writedata[0];
        2'd2:    clr_req_s = MMS_writedata[0];
        default: clr_req_s = 1'b0;
      endcase
    end else begin
      clr_req_s = 1'b0;
    end
  end

  // Fault latch: set beats clear, and a clear is honoured only while trip_n is high.
  // Gates are forced off on the same edge the latch sets.
  always_comb begin
    fault_set_s = enable_q & (~trip_n | shoot_s);
    if (fault_set_s) begin
      fault_d = 1'b1;
    end else if (clr_req_s && trip_n) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
    faultirq_d   = fault_d & ~fault_q;
    force_idle_s = fault_d | ~enable_q;
  end

  // Per-phase dead-time FSM; gate drives are decoded from the next state so they
  // follow a request change by exactly one clk.
  always_comb begin
    for (int i = 0; i < NPH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (force_idle_s) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = dt_q;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            // Free-running saturating countdown; requests never restart it.
            if (cnt_q[i] == DT_ZERO) begin
              cnt_d[i] = DT_ZERO;
              if (req_s[i] == REQ_U) begin
                state_d[i] = ST_U_ON;
              end else if (req_s[i] == REQ_L) begin
                state_d[i] = ST_L_ON;
              end else begin
                state_d[i] = ST_IDLE;
              end
            end else begin
              cnt_d[i]   = cnt_q[i] - DT_ONE;
              state_d[i] = ST_IDLE;
            end
          end
          ST_U_ON: begin
            if (req_s[i] != REQ_U) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = dt_q;
            end else begin
              state_d[i] = ST_U_ON;
            end
          end
          ST_L_ON: begin
            if (req_s[i] != REQ_L) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = dt_q;
            end else begin
              state_d[i] = ST_L_ON;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = dt_q;
          end
        endcase
      end
      ugate_d[i] = (state_d[i] == ST_U_ON);
      lgate_d[i] = (state_d[i] == ST_L_ON);
    end
  end

  // State registers with synchronous reset to the safe all-off condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      dt_q       <= DT_ONES;
      enable_q   <= 1'b0;
      fault_q    <= 1'b0;
      faultirq_q <= 1'b0;
      ugate_q    <= 3'b000;
      lgate_q    <= 3'b000;
      for (int i = 0; i < NPH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= DT_ONES;
      end
    end else begin
      dt_q       <= dt_d;
      enable_q   <= enable_d;
      fault_q    <= fault_d;
      faultirq_q <= faultirq_d;
      ugate_q    <= ugate_d;
      lgate_q    <= lgate_d;
      for (int i = 0; i < NPH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign Ugate    = ugate_q;
  assign Lgate    = lgate_q;
  assign faultirq = faultirq_q;

endmodule

// File: tb/tb_deadtime_gate.sv
// -----------------------------------------------------------------------------
// tb_deadtime_gate
//   Directed bench for deadtime_gate.
//   - A vector table walks through register writes, dead-time gaps and fault
//     handling.
//   - Hand-written sequences cover the multi-cycle timing corners: gap length,
//     mid-count dead-time change, per-cycle toggling, shoot-through and
//     mid-operation reset.
// -----------------------------------------------------------------------------
module tb_deadtime_gate;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  MMS_addr = 2'd0;
  logic        MMS_write = 1'b0;
  logic [31:0] MMS_writedata = 32'd0;
  logic [0:2]  Udrive = 3'b000;
  logic [0:2]  Ldrive = 3'b000;
  logic        trip_n = 1'b1;
  logic [0:2]  Ugate;
  logic [0:2]  Lgate;
  logic        faultirq;

  int n_checks = 0;
  int n_fail = 0;
  int overlap_cnt = 0;

  deadtime_gate #(.DT_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .MMS_addr     (MMS_addr),
    .MMS_write    (MMS_write),
    .MMS_writedata(MMS_writedata),
    .Udrive       (Udrive),
    .Ldrive       (Ldrive),
    .trip_n       (trip_n),
    .Ugate        (Ugate),
    .Lgate        (Lgate),
    .faultirq     (faultirq)
  );

  always #5 clk = ~clk;

  // Complementary gates of one phase must never be on together.
  always @(negedge clk) begin
    if (|(Ugate & Lgate)) overlap_cnt++;
  end

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [0:2]  u;
    logic [0:2]  l;
    logic        trip_n;
    logic [0:2]  eu;
    logic [0:2]  el;
    logic        eirq;
  } vec_t;

  vec_t tbl [0:22];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    MMS_addr = a;
    MMS_writedata = d;
    MMS_write = 1'b1;
    tick();
    MMS_write = 1'b0;
    MMS_addr = 2'd0;
    MMS_writedata = 32'd0;
  endtask

  // Count edges until the selected gate is high, giving up after budget edges.
  task automatic wait_gate(input logic hi_side, input int ph, input int budget, output int n);
    n = 0;
    while (((hi_side ? Ugate[ph] : Lgate[ph]) !== 1'b1) && (n < budget)) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int n;

  initial begin
    // addr, wr, wdata, U, L, trip_n, expected Ugate, Lgate, faultirq
    tbl[0]  = '{2'd0, 1'b1, 32'd2,          3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[1]  = '{2'd1, 1'b1, 32'd1,          3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[2]  = '{2'd0, 1'b0, 32'd0,          3'b100, 3'b010, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[3]  = '{2'd0, 1'b0, 32'd0,          3'b100, 3'b010, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[4]  = '{2'd0, 1'b0, 32'd0,          3'b100, 3'b010, 1'b1, 3'b100, 3'b010, 1'b0};
    tbl[5]  = '{2'd0, 1'b0, 32'd0,          3'b100, 3'b010, 1'b1, 3'b100, 3'b010, 1'b0};
    tbl[6]  = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[7]  = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[8]  = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[9]  = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b100, 1'b0};
    tbl[10] = '{2'd3, 1'b1, 32'hFFFF_FFFF,  3'b000, 3'b100, 1'b1, 3'b000, 3'b100, 1'b0};
    tbl[11] = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b0, 3'b000, 3'b000, 1'b1};
    tbl[12] = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[13] = '{2'd2, 1'b1, 32'd1,          3'b000, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[14] = '{2'd2, 1'b1, 32'd1,          3'b000, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[15] = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[16] = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b100, 1'b0};
    tbl[17] = '{2'd1, 1'b1, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b100, 1'b0};
    tbl[18] = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0};
    tbl[19] = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[20] = '{2'd1, 1'b1, 32'd1,          3'b000, 3'b100, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[21] = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b0, 3'b000, 3'b000, 1'b1};
    tbl[22] = '{2'd0, 1'b0, 32'd0,          3'b000, 3'b100, 1'b1, 3'b000, 3'b000, 1'b0};

    // Reset state
    tick();
    tick();
    chk("reset ugate", 32'(Ugate), 32'd0);
    chk("reset lgate", 32'(Lgate), 32'd0);
    chk("reset irq", 32'(faultirq), 32'd0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i <= 22; i++) begin
      MMS_addr = tbl[i].addr;
      MMS_write = tbl[i].wr;
      MMS_writedata = tbl[i].wdata;
      Udrive = tbl[i].u;
      Ldrive = tbl[i].l;
      trip_n = tbl[i].trip_n;
      tick();
      chk($sformatf("row%0d ugate", i), 32'(Ugate), 32'(tbl[i].eu));
      chk($sformatf("row%0d lgate", i), 32'(Lgate), 32'(tbl[i].el));
      chk($sformatf("row%0d irq", i), 32'(faultirq), 32'(tbl[i].eirq));
    end
    MMS_write = 1'b0;
    trip_n = 1'b1;
    Udrive = 3'b000;
    Ldrive = 3'b000;

    // Dead-time 5: L-to-U gap on phase 0
    do_reset();
    wr(2'd0, 32'd5);
    wr(2'd1, 32'd1);
    Ldrive = 3'b100;
    wait_gate(1'b0, 0, 30, n);
    chk("dt5 first L on", 32'(n), 32'd6);
    tick();
    tick();
    Udrive = 3'b100;
    Ldrive = 3'b000;
    tick();
    chk("dt5 L off", 32'(Lgate[0]), 32'd0);
    chk("dt5 U still off", 32'(Ugate[0]), 32'd0);
    wait_gate(1'b1, 0, 30, n);
    chk("dt5 gap", 32'(n), 32'd6);

    // Dead-time 10, rewritten to 2 mid-count
    wr(2'd0, 32'd10);
    Udrive = 3'b000;
    Ldrive = 3'b100;
    tick();
    chk("dt10 U off", 32'(Ugate[0]), 32'd0);
    tick();
    tick();
    tick();
    wr(2'd0, 32'd2);
    wait_gate(1'b0, 0, 30, n);
    chk("dt10 current gap", 32'(n + 4), 32'd11);
    Udrive = 3'b100;
    Ldrive = 3'b000;
    tick();
    chk("dt2 L off", 32'(Lgate[0]), 32'd0);
    wait_gate(1'b1, 0, 30, n);
    chk("dt2 next gap", 32'(n), 32'd3);

    // Dead-time 0: per-cycle toggling on phase 1, then a held request
    wr(2'd0, 32'd0);
    for (int i = 0; i < 20; i++) begin
      Udrive[1] = (i % 2 == 0);
      Ldrive[1] = (i % 2 != 0);
      tick();
    end
    Udrive[1] = 1'b0;
    Ldrive[1] = 1'b1;
    wait_gate(1'b0, 1, 10, n);
    chk("dt0 L on", 32'(Lgate[1]), 32'd1);
    Udrive[1] = 1'b1;
    Ldrive[1] = 1'b0;
    tick();
    chk("dt0 L off", 32'(Lgate[1]), 32'd0);
    chk("dt0 gap low", 32'(Ugate[1]), 32'd0);
    tick();
    chk("dt0 U on 2nd edge", 32'(Ugate[1]), 32'd1);

    // Both demands high on phase 0 for one cycle
    Ldrive[0] = 1'b1;
    tick();
`ifdef SHOOT_THROUGH_DETECT_EN
    chk("shoot gates off", 32'(Ugate), 32'd0);
    chk("shoot irq", 32'(faultirq), 32'd1);
    Ldrive[0] = 1'b0;
    tick();
    chk("shoot irq once", 32'(faultirq), 32'd0);
    chk("shoot fault held", 32'(Ugate), 32'd0);
`else
    chk("both-high U0 off", 32'(Ugate[0]), 32'd0);
    chk("both-high U1 kept", 32'(Ugate[1]), 32'd1);
    chk("both-high no irq", 32'(faultirq), 32'd0);
    Ldrive[0] = 1'b0;
    tick();
    chk("both-high recover", 32'(Ugate[0]), 32'd1);
    chk("both-high no irq 2", 32'(faultirq), 32'd0);
`endif

    // Reset mid-operation with a simultaneous dead-time write
    reset = 1'b1;
    MMS_addr = 2'd0;
    MMS_writedata = 32'd3;
    MMS_write = 1'b1;
    tick();
    chk("midreset ugate", 32'(Ugate), 32'd0);
    chk("midreset lgate", 32'(Lgate), 32'd0);
    chk("midreset irq", 32'(faultirq), 32'd0);
    reset = 1'b0;
    MMS_write = 1'b0;
    MMS_writedata = 32'd0;
    Udrive = 3'b100;
    Ldrive = 3'b000;
    wr(2'd1, 32'd1);
    wait_gate(1'b1, 0, 400, n);
    chk("reset dead-time all ones", 32'(n), 32'd256);

    chk("no overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
